dma_multichannel: RTL and testbench

//   NCH-channel DMA engine, successor to the single-path dma. Moves words RAM->RAM, IO->RAM (rx) or
//   RAM->IO (tx), one word per grant. Channels are arbitrated round-robin. Sits between cpu, ram and io.
//   The CPU programs and monitors channels through a small register bus; completion raises an irq.

---
 rtl/dma_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/dma_multichannel.sv | 227 ++++++++++++++++++++++
 tb/tb_dma_multichannel.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared constants for the multichannel DMA: register map, mode encodings, CTRL bits, FSM states.
// Pure declarations, no logic; no latency.
// No flow control of its own.
package dma_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam logic [1:0] MODE_M2M = 2'b00;
    localparam logic [1:0] MODE_RX  = 2'b01;
    localparam logic [1:0] MODE_TX  = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_DONE   = 4;
    localparam int CTRL_ABORT  = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARB  = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last granted requester.
// Grant is combinational from req; pointer moves on the clock edge where advance is high.
// No backpressure; an empty req vector gives an all-zero grant and leaves the pointer alone.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    logic [N-1:0] last;
    logic [N-1:0] mask_hi;
    logic [N-1:0] req_hi;

    // Requesters above the last grant win first; otherwise wrap to the lowest requester.
    assign mask_hi = ~((last << 1) - N'(1));
    assign req_hi  = req & mask_hi;
    assign grant   = (|req_hi) ? (req_hi & (~req_hi + N'(1))) : (req & (~req + N'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= N'(1) << (N - 1);
        end else if (advance && |req) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/dma_multichannel.sv
// NCH-channel DMA (mem2mem / rx / tx), one word per round-robin grant, CPU register bus, irq.
// Latency: 3 cycles per word (ARB, RD, WR) uncontended; LEN=0 completes one cycle after start.
// Backpressure: rx waits for io_rx_valid before grant; tx holds io_tx_valid/data in WR until io_tx_ready.
module dma_multichannel
    import dma_pkg::*;
#(
    parameter int SZ  = 8,
    parameter int WSZ = 8,
    parameter int NCH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(NCH)+2-1:0]   cpu_addr,
    input  logic                       cpu_w_notr,
    input  logic [WSZ-1:0]             cpu_wdata,
    output logic [WSZ-1:0]             cpu_rdata,
    output logic                       irq,
    output logic [SZ-1:0]              ram_addr,
    output logic                       ram_w_notr,
    output logic [WSZ-1:0]             ram_wdata,
    input  logic [WSZ-1:0]             ram_rdata,
    input  logic                       io_rx_valid,
    input  logic [WSZ-1:0]             io_rx_data,
    output logic                       io_rx_ready,
    input  logic                       io_tx_ready,
    output logic                       io_tx_valid,
    output logic [WSZ-1:0]             io_tx_data
);

    localparam int AW  = $clog2(NCH) + 2;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [SZ-1:0]  src [NCH];
    logic [SZ-1:0]  dst [NCH];
    logic [SZ-1:0]  len [NCH];
    logic [1:0]     mode [NCH];
    logic [WSZ-1:0] ctrl_dat [NCH];
    logic [NCH-1:0] busy, done, irq_en, elig, gnt_oh, ctrl_apply;

    logic [1:0]     state;
    logic [CHW-1:0] gnt_ch, arb_ch;
    logic [WSZ-1:0] hold, pend_dat;
    logic           pend_vld;
    logic [AW-1:0]  cpu_ch;
    logic [1:0]     cpu_reg, gmode;
    logic           rd_st, wr_st, xfer, g_ctrl_wr, g_abort, wr_done, commit, leave;

    assign cpu_ch  = cpu_addr >> 2;
    assign cpu_reg = cpu_addr[1:0];
    assign rd_st   = (state == ST_RD);
    assign wr_st   = (state == ST_WR);
    assign xfer    = rd_st | wr_st;
    assign gmode   = mode[gnt_ch];

    // A granted channel that lost busy (aborted on the grant edge) is treated like an abort.
    assign g_ctrl_wr = xfer && cpu_w_notr && (cpu_reg == REG_CTRL) && (cpu_ch == AW'(gnt_ch));
    assign g_abort   = xfer && ((g_ctrl_wr && cpu_wdata[CTRL_ABORT]) || !busy[gnt_ch]);
    assign wr_done   = wr_st && ((gmode != MODE_TX) || io_tx_ready);
    assign commit    = wr_done && !g_abort;
    assign leave     = (rd_st && g_abort) || (wr_st && (wr_done || g_abort));
    assign irq       = |(done & irq_en);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            elig[i] = busy[i] && (len[i] != '0) &&
                      ((mode[i] == MODE_M2M) ||
                       ((mode[i] == MODE_RX) && io_rx_valid) ||
                       ((mode[i] == MODE_TX) && io_tx_ready));
        end
    end

    rr_arbiter #(.N(NCH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .advance (state == ST_ARB),
        .grant   (gnt_oh)
    );

    always_comb begin
        arb_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_oh[i]) arb_ch = CHW'(i);
        end
    end

    // CTRL writes to the granted channel are held back until it leaves RD/WR.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ctrl_apply[i] = 1'b0;
            ctrl_dat[i]   = cpu_wdata;
            if (xfer && (gnt_ch == CHW'(i))) begin
                if (leave && (g_ctrl_wr || pend_vld)) begin
                    ctrl_apply[i] = 1'b1;
                    ctrl_dat[i]   = (g_ctrl_wr ? cpu_wdata : '0) | pend_dat;
                end
            end else if (cpu_w_notr && (cpu_reg == REG_CTRL) && (cpu_ch == AW'(i))) begin
                ctrl_apply[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld <= 1'b0;
            pend_dat <= '0;
        end else if (leave) begin
            pend_vld <= 1'b0;
            pend_dat <= '0;
        end else if (g_ctrl_wr) begin
            pend_vld <= 1'b1;
            pend_dat <= pend_dat | cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            gnt_ch <= '0;
            hold   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (|busy) state <= ST_ARB;
                ST_ARB: begin
                    if (|elig) begin
                        state  <= ST_RD;
                        gnt_ch <= arb_ch;
                    end else if (!(|busy)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    hold  <= (gmode == MODE_RX) ? io_rx_data : ram_rdata;
                    state <= g_abort ? ST_ARB : ST_WR;
                end
                default: if (leave) state <= ST_ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy   <= '0;
            done   <= '0;
            irq_en <= '0;
            for (int i = 0; i < NCH; i++) begin
                src[i]  <= '0;
                dst[i]  <= '0;
                len[i]  <= '0;
                mode[i] <= MODE_M2M;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (busy[i] && (len[i] == '0) && !(xfer && (gnt_ch == CHW'(i)))) begin
                    busy[i] <= 1'b0;
                    done[i] <= 1'b1;
                end
                if (!busy[i] && cpu_w_notr && (cpu_ch == AW'(i))) begin
                    case (cpu_reg)
                        REG_SRC: src[i] <= SZ'(cpu_wdata);
                        REG_DST: dst[i] <= SZ'(cpu_wdata);
                        REG_LEN: len[i] <= SZ'(cpu_wdata);
                        default: ;
                    endcase
                end
                if (commit && (gnt_ch == CHW'(i))) begin
                    if (gmode != MODE_RX) src[i] <= src[i] + SZ'(1);
                    if (gmode != MODE_TX) dst[i] <= dst[i] + SZ'(1);
                    len[i] <= len[i] - SZ'(1);
                    if (len[i] == SZ'(1)) begin
                        busy[i] <= 1'b0;
                        done[i] <= 1'b1;
                    end
                end
                if (ctrl_apply[i]) begin
                    irq_en[i] <= ctrl_dat[i][CTRL_IRQ_EN];
                    if (ctrl_dat[i][CTRL_DONE]) done[i] <= 1'b0;
                    if (!busy[i]) mode[i] <= ctrl_dat[i][CTRL_MODE +: 2];
                    if (ctrl_dat[i][CTRL_ABORT]) begin
                        busy[i] <= 1'b0;
                    end else if (ctrl_dat[i][CTRL_START] && !busy[i] &&
                                 (ctrl_dat[i][CTRL_MODE +: 2] != MODE_RSV)) begin
                        busy[i] <= 1'b1;
                        done[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        ram_addr    = '0;
        ram_w_notr  = 1'b0;
        ram_wdata   = '0;
        io_rx_ready = 1'b0;
        io_tx_valid = 1'b0;
        io_tx_data  = '0;
        if (rd_st) begin
            if (gmode == MODE_RX) io_rx_ready = 1'b1;
            else                  ram_addr    = src[gnt_ch];
        end else if (wr_st) begin
            if (gmode == MODE_TX) begin
                io_tx_valid = 1'b1;
                io_tx_data  = hold;
            end else begin
                ram_addr   = dst[gnt_ch];
                ram_w_notr = 1'b1;
                ram_wdata  = hold;
            end
        end
    end

    always_comb begin
        cpu_rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cpu_ch == AW'(i)) begin
                case (cpu_reg)
                    REG_SRC: cpu_rdata = WSZ'(src[i]);
                    REG_DST: cpu_rdata = WSZ'(dst[i]);
                    REG_LEN: cpu_rdata = WSZ'(len[i]);
                    default: cpu_rdata = WSZ'({done[i], irq_en[i], mode[i], busy[i]});
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_multichannel.sv
// Directed bench for dma_multichannel: expected RAM writes / tx words go into queues,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_dma_multichannel;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cpu_addr;
    logic          cpu_w_notr;
    logic [7:0]    cpu_wdata, cpu_rdata;
    logic          irq;
    logic [7:0]    ram_addr, ram_wdata, ram_rdata;
    logic          ram_w_notr;
    logic          io_rx_valid, io_rx_ready, io_tx_ready, io_tx_valid;
    logic [7:0]    io_rx_data, io_tx_data;

    logic [7:0]    ram [256];
    logic [15:0]   exp_wr [$];
    logic [7:0]    exp_tx [$];
    int            n_chk = 0, n_pass = 0;
    int            wr_cnt = 0, rx_cnt = 0, tx_cnt = 0;
    int            base, rbase;

    dma_multichannel #(.SZ(8), .WSZ(8), .NCH(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_w_notr(cpu_w_notr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .irq(irq),
        .ram_addr(ram_addr), .ram_w_notr(ram_w_notr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_rx_valid(io_rx_valid), .io_rx_data(io_rx_data), .io_rx_ready(io_rx_ready),
        .io_tx_ready(io_tx_ready), .io_tx_valid(io_tx_valid), .io_tx_data(io_tx_data)
    );

    always #5 clk = ~clk;

    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) if (ram_w_notr) ram[ram_addr] <= ram_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (ram_w_notr) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    n_chk++;
                    $display("FAIL ram_wr: got %h@%h required no write", ram_wdata, ram_addr);
                end else begin
                    check("ram_wr", {ram_addr, ram_wdata}, exp_wr.pop_front());
                end
            end
            if (io_rx_ready) rx_cnt++;
            if (io_tx_valid && io_tx_ready) begin
                tx_cnt++;
                if (exp_tx.size() == 0) begin
                    n_chk++;
                    $display("FAIL tx_word: got %h required no word", io_tx_data);
                end else begin
                    check("tx_word", io_tx_data, exp_tx.pop_front());
                end
            end
        end
    end

    task automatic cpu_write(input int ch, input int r, input logic [7:0] d);
        cpu_addr   = AW'(ch * 4 + r);
        cpu_wdata  = d;
        cpu_w_notr = 1'b1;
        @(posedge clk); #1;
        cpu_w_notr = 1'b0;
    endtask

    task automatic cpu_read(input int ch, input int r, output logic [7:0] d);
        cpu_addr = AW'(ch * 4 + r);
        #2;
        d = cpu_rdata;
    endtask

    task automatic rd_check(input string name, input int ch, input int r, input logic [7:0] exp);
        logic [7:0] d;
        cpu_read(ch, r, d);
        check(name, d, exp);
    endtask

    task automatic setup(input int ch, input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        cpu_write(ch, 0, s);
        cpu_write(ch, 1, d);
        cpu_write(ch, 2, l);
    endtask

    task automatic wait_done(input string name, input int ch);
        logic [7:0] d = '0;
        for (int i = 0; i < 200; i++) begin
            cpu_read(ch, 3, d);
            if (d[4]) break;
            @(posedge clk); #1;
        end
        check(name, d[4], 1'b1);
    endtask

    task automatic wait_wr(input string name, input int n);
        for (int i = 0; i < 200; i++) begin
            if (wr_cnt >= n) break;
            @(posedge clk); #1;
        end
        check(name, wr_cnt, n);
    endtask

    initial begin
        rst = 1'b0; cpu_addr = '0; cpu_w_notr = 1'b0; cpu_wdata = '0;
        io_rx_valid = 1'b0; io_rx_data = '0; io_tx_ready = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_w", ram_w_notr, 1'b0);
        check("rst_ram_addr", ram_addr, 8'h00);
        check("rst_rx_ready", io_rx_ready, 1'b0);
        check("rst_tx_valid", io_tx_valid, 1'b0);
        check("rst_irq", irq, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rd_check("rst_ctrl0", 0, 3, 8'h00);

        // mem2mem ch0 with irq
        ram[8'h10] = 8'hA1; ram[8'h11] = 8'hB2; ram[8'h12] = 8'hC3;
        exp_wr.push_back(16'h80A1); exp_wr.push_back(16'h81B2); exp_wr.push_back(16'h82C3);
        setup(0, 8'h10, 8'h80, 8'd3);
        cpu_write(0, 3, 8'h09);
        wait_done("t1_done", 0);
        check("t1_irq", irq, 1'b1);
        rd_check("t1_ctrl", 0, 3, 8'h18);
        rd_check("t1_src", 0, 0, 8'h13);
        rd_check("t1_dst", 0, 1, 8'h83);
        rd_check("t1_len", 0, 2, 8'h00);
        check("t1_ram82", ram[8'h82], 8'hC3);
        cpu_write(0, 3, 8'h18);
        check("t1_irq_clr", irq, 1'b0);
        rd_check("t1_ctrl_clr", 0, 3, 8'h08);
        check("t1_queue", exp_wr.size(), 0);

        // LEN=0 start
        base = wr_cnt;
        cpu_write(1, 2, 8'h00);
        cpu_write(1, 3, 8'h01);
        rd_check("t2_busy", 1, 3, 8'h01);
        @(posedge clk); #1;
        rd_check("t2_done", 1, 3, 8'h10);
        repeat (4) begin @(posedge clk); #1; end
        check("t2_nowr", wr_cnt, base);

        // address wrap
        ram[8'hFE] = 8'h11; ram[8'hFF] = 8'h22; ram[8'h00] = 8'h33; ram[8'h01] = 8'h44;
        exp_wr.push_back(16'h4011); exp_wr.push_back(16'h4122);
        exp_wr.push_back(16'h4233); exp_wr.push_back(16'h4344);
        setup(2, 8'hFE, 8'h40, 8'd4);
        cpu_write(2, 3, 8'h01);
        wait_done("t3_done", 2);
        rd_check("t3_dst", 2, 1, 8'h44);
        rd_check("t3_src", 2, 0, 8'h02);
        check("t3_queue", exp_wr.size(), 0);

        // two channels interleave
        ram[8'h20] = 8'h5A; ram[8'h21] = 8'h5B; ram[8'h30] = 8'h6A; ram[8'h31] = 8'h6B;
        exp_wr.push_back(16'h905A); exp_wr.push_back(16'hA06A);
        exp_wr.push_back(16'h915B); exp_wr.push_back(16'hA16B);
        setup(0, 8'h20, 8'h90, 8'd2);
        setup(1, 8'h30, 8'hA0, 8'd2);
        cpu_write(0, 3, 8'h01);
        cpu_write(1, 3, 8'h01);
        wait_done("t4_done0", 0);
        wait_done("t4_done1", 1);
        check("t4_queue", exp_wr.size(), 0);

        // rx with delayed valid
        exp_wr.push_back(16'hC077); exp_wr.push_back(16'hC178);
        setup(3, 8'h00, 8'hC0, 8'd2);
        base = wr_cnt; rbase = rx_cnt;
        cpu_write(3, 3, 8'h03);
        repeat (5) begin @(posedge clk); #1; end
        check("t5_nowr", wr_cnt, base);
        check("t5_norx", rx_cnt, rbase);
        io_rx_data = 8'h77; io_rx_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rx_cnt == rbase + 1) io_rx_data = 8'h78;
            if (rx_cnt == rbase + 2) begin io_rx_valid = 1'b0; break; end
        end
        io_rx_valid = 1'b0;
        wait_done("t5_done", 3);
        check("t5_rx_pulses", rx_cnt, rbase + 2);
        rd_check("t5_dst", 3, 1, 8'hC2);
        check("t5_queue", exp_wr.size(), 0);

        // tx with ready stalled in WR
        ram[8'h50] = 8'hE7;
        exp_tx.push_back(8'hE7);
        base = tx_cnt;
        cpu_write(1, 0, 8'h50);
        cpu_write(1, 2, 8'd1);
        io_tx_ready = 1'b1;
        cpu_write(1, 3, 8'h05);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (io_tx_valid) break;
        end
        io_tx_ready = 1'b0;
        check("t6_valid_seen", io_tx_valid, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("t6_valid_hold", io_tx_valid, 1'b1);
            check("t6_data_hold", io_tx_data, 8'hE7);
        end
        check("t6_no_early", tx_cnt, base);
        io_tx_ready = 1'b1;
        wait_done("t6_done", 1);
        io_tx_ready = 1'b0;
        check("t6_tx_cnt", tx_cnt, base + 1);
        rd_check("t6_src", 1, 0, 8'h51);

        // abort between words, then abort during RD
        ram[8'h60] = 8'hC6; ram[8'h61] = 8'hC7; ram[8'h62] = 8'hC8;
        exp_wr.push_back(16'hB0C6); exp_wr.push_back(16'hB1C7);
        base = wr_cnt;
        setup(0, 8'h60, 8'hB0, 8'd8);
        cpu_write(0, 3, 8'h01);
        wait_wr("t7_two", base + 2);
        cpu_write(0, 3, 8'h20);
        repeat (4) begin @(posedge clk); #1; end
        check("t7_wr_cnt", wr_cnt, base + 2);
        rd_check("t7_ctrl", 0, 3, 8'h00);
        rd_check("t7_len", 0, 2, 8'h06);
        rd_check("t7_src", 0, 0, 8'h62);
        rd_check("t7_dst", 0, 1, 8'hB2);
        exp_wr.push_back(16'hB2C8);
        base = wr_cnt;
        cpu_write(0, 3, 8'h01);
        wait_wr("t7b_one", base + 1);
        @(posedge clk); #1;
        cpu_write(0, 3, 8'h20);
        repeat (4) begin @(posedge clk); #1; end
        check("t7b_wr_cnt", wr_cnt, base + 1);
        rd_check("t7b_len", 0, 2, 8'h05);
        rd_check("t7b_src", 0, 0, 8'h63);
        rd_check("t7b_ctrl", 0, 3, 8'h00);
        check("t7_queue", exp_wr.size(), 0);

        // reset mid-transfer
        ram[8'h70] = 8'hD7;
        exp_wr.push_back(16'hD0D7);
        base = wr_cnt;
        setup(2, 8'h70, 8'hD0, 8'd5);
        cpu_write(2, 3, 8'h01);
        wait_wr("t8_one", base + 1);
        rst = 1'b0;
        #1;
        check("t8_ram_w", ram_w_notr, 1'b0);
        check("t8_ram_addr", ram_addr, 8'h00);
        check("t8_tx_valid", io_tx_valid, 1'b0);
        check("t8_rx_ready", io_rx_ready, 1'b0);
        check("t8_irq", irq, 1'b0);
        rd_check("t8_ctrl", 2, 3, 8'h00);
        rd_check("t8_len", 2, 2, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("t8_no_wr", wr_cnt, base + 1);
        rd_check("t8_ctrl_after", 2, 3, 8'h00);
        check("t8_queue", exp_wr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
